// File: rtl/mult_share_arbiter.sv
// Round-robin front end sharing one pipelined multiplier between requesters.
// A tag pipe tracks ownership so each product goes back to the requester that issued it.
module mult_share_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DIN_W     = 8,
    parameter int DOUT_W    = 2*DIN_W,
    parameter int MULT_LAT  = 3,
    parameter int MAX_OUTST = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid_i,
    output logic [NUM_REQ-1:0]         req_ready_o,
    input  logic [NUM_REQ*DIN_W-1:0]   req_a_i,
    input  logic [NUM_REQ*DIN_W-1:0]   req_b_i,
    output logic [DIN_W-1:0]           mult_a_o,
    output logic [DIN_W-1:0]           mult_b_o,
    input  logic [DOUT_W-1:0]          mult_product_i,
    output logic [NUM_REQ-1:0]         resp_valid_o,
    output logic [DOUT_W-1:0]          resp_product_o,
    output logic                       busy_o
);

    localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(MAX_OUTST + 1);
    localparam int DEPTH = MULT_LAT + 1;

    typedef struct packed {
        logic            vld;
        logic [ID_W-1:0] id;
    } tag_t;

    logic [ID_W-1:0]    r_last;
    logic [CNT_W-1:0]   r_cnt [NUM_REQ];
    tag_t               r_tag [DEPTH];
    logic [DIN_W-1:0]   r_a;
    logic [DIN_W-1:0]   r_b;
    logic [NUM_REQ-1:0] r_resp_valid;
    logic [DOUT_W-1:0]  r_resp_product;

    logic [NUM_REQ-1:0] w_elig;
    logic [NUM_REQ-1:0] w_grant;
    logic [NUM_REQ-1:0] w_dec;
    logic               w_accept;
    logic [ID_W-1:0]    w_gid;
    tag_t               w_exit;
    logic               w_busy;

    // Eligibility looks at the count before this cycle's response retires
    always_comb begin
        w_elig = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_elig[i] = req_valid_i[i] && (r_cnt[i] < CNT_W'(MAX_OUTST));
        end
    end

    always_comb begin : rr_pick
        int idx;
        idx      = 0;
        w_accept = 1'b0;
        w_gid    = '0;
        w_grant  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(r_last) + k) % NUM_REQ;
            if (!w_accept && !rst && w_elig[idx]) begin
                w_accept = 1'b1;
                w_gid    = ID_W'(idx);
            end
        end
        if (w_accept) begin
            w_grant[w_gid] = 1'b1;
        end
    end

    assign w_exit = r_tag[DEPTH-1];

    always_comb begin
        w_dec = '0;
        if (w_exit.vld) begin
            w_dec[w_exit.id] = 1'b1;
        end
    end

    always_comb begin
        w_busy = |r_resp_valid;
        for (int i = 0; i < DEPTH; i++) begin
            w_busy = w_busy | r_tag[i].vld;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last         <= ID_W'(NUM_REQ - 1);
            r_a            <= '0;
            r_b            <= '0;
            r_resp_valid   <= '0;
            r_resp_product <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_tag[i] <= '0;
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            if (w_accept) begin
                r_a    <= req_a_i[w_gid*DIN_W +: DIN_W];
                r_b    <= req_b_i[w_gid*DIN_W +: DIN_W];
                r_last <= w_gid;
            end else begin
                r_a <= '0;
                r_b <= '0;
            end
            r_tag[0] <= {w_accept, w_gid};
            for (int i = 1; i < DEPTH; i++) begin
                r_tag[i] <= r_tag[i-1];
            end
            r_resp_valid   <= w_dec;
            r_resp_product <= mult_product_i;
            for (int i = 0; i < NUM_REQ; i++) begin
                case ({w_grant[i], r_resp_valid[i]})
                    2'b10:   r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                    2'b01:   r_cnt[i] <= r_cnt[i] - CNT_W'(1);
                    default: r_cnt[i] <= r_cnt[i];
                endcase
            end
        end
    end

    assign req_ready_o    = w_grant;
    assign mult_a_o       = r_a;
    assign mult_b_o       = r_b;
    assign resp_valid_o   = r_resp_valid;
    assign resp_product_o = r_resp_product;
    assign busy_o         = w_busy;

endmodule
